// File: rtl/el_pkg.sv
`default_nettype none
// ============================================================================
// el_pkg : screen geometry defaults, control codes and FSM encoding shared by
//          the character RAM writer.          Rev 1.0
// ============================================================================
package el_pkg;

  localparam int         COLS_DEFAULT      = 40;
  localparam int         ROWS_DEFAULT      = 32;
  localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

  localparam logic [7:0] LF              = 8'h0A;
  localparam logic [7:0] CR              = 8'h0D;
  localparam logic [7:0] BS              = 8'h08;
  localparam logic [7:0] FF              = 8'h0C;
  localparam logic [7:0] FIRST_PRINTABLE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_CLEAR_ROW = 2'd2,
    ST_CLEAR_ALL = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/char_ram_writer.sv
`default_nettype none
// ============================================================================
// char_ram_writer : turns a host byte stream into character-RAM writes with
//                   cursor tracking, row clear on new line and full clear.
//                   Rev 1.0
// ============================================================================
module char_ram_writer
  import el_pkg::*;
#(
  parameter int         COLS      = COLS_DEFAULT,
  parameter int         ROWS      = ROWS_DEFAULT,
  parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEFAULT
) (
  input  logic        in_main_clock,
  input  logic        in_reset_n,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        out_ready,
  output logic [10:0] out_wr_address,
  output logic [7:0]  out_wr_data,
  output logic        out_wr_en,
  output logic [5:0]  out_cursor_x,
  output logic [4:0]  out_cursor_y,
  output logic        out_busy
);

  localparam logic [5:0]  LAST_COL    = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
  localparam logic [10:0] COLS_W      = 11'(COLS);
  localparam logic [10:0] ROW_LAST    = 11'(COLS - 1);
  localparam logic [10:0] SCREEN_LAST = 11'(COLS * ROWS - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [5:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [4:0]  w_next_row;
  logic [10:0] w_row_base;
  logic [10:0] w_next_row_base;
  logic [10:0] w_cell_addr;

  assign w_next_row      = (cur_y_q == LAST_ROW) ? 5'd0 : cur_y_q + 5'd1;
  assign w_row_base      = {6'd0, cur_y_q} * COLS_W;
  assign w_next_row_base = {6'd0, w_next_row} * COLS_W;
  assign w_cell_addr     = w_row_base + {5'd0, cur_x_q};

  always_ff @(posedge in_main_clock) begin
    if (!in_reset_n) begin
      state_q   <= ST_CLEAR_ALL;
      cnt_q     <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Write port is registered: a cell is loaded onto the port on the edge that
  // enters (or stays in) the state writing it, and the cursor moves on accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_char >= FIRST_PRINTABLE) begin
            state_d   = ST_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = w_cell_addr;
            wr_data_d = in_char;
            if (cur_x_q < LAST_COL) begin
              cur_x_d = cur_x_q + 6'd1;
            end else begin
              cur_x_d = '0;
              cur_y_d = w_next_row;
            end
          end else begin
            case (in_char)
              LF: begin
                cur_x_d   = '0;
                cur_y_d   = w_next_row;
                state_d   = ST_CLEAR_ROW;
                wr_en_d   = 1'b1;
                wr_addr_d = w_next_row_base;
                wr_data_d = FILL_CHAR;
                cnt_d     = '0;
              end
              CR: cur_x_d = '0;
              BS: begin
                if (cur_x_q != 6'd0) cur_x_d = cur_x_q - 6'd1;
              end
              FF: begin
                state_d   = ST_CLEAR_ALL;
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = FILL_CHAR;
                cnt_d     = '0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: begin
        // Cursor already advanced; column 0 here means the write wrapped a row.
        if (cur_x_q == 6'd0) begin
          state_d   = ST_CLEAR_ROW;
          wr_en_d   = 1'b1;
          wr_addr_d = w_row_base;
          wr_data_d = FILL_CHAR;
          cnt_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR_ROW: begin
        if (cnt_q == ROW_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          cnt_d     = cnt_q + 11'd1;
          wr_addr_d = wr_addr_q + 11'd1;
        end
      end

      ST_CLEAR_ALL: begin
        // Coming out of reset nothing is on the port yet, so present cell 0.
        if (!wr_en_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = FILL_CHAR;
          cnt_d     = '0;
        end else if (cnt_q == SCREEN_LAST) begin
          state_d = ST_IDLE;
          cur_x_d = '0;
          cur_y_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          cnt_d     = cnt_q + 11'd1;
          wr_addr_d = wr_addr_q + 11'd1;
        end
      end

      default: state_d = ST_CLEAR_ALL;
    endcase
  end

  assign out_ready      = (state_q == ST_IDLE);
  assign out_busy       = (state_q != ST_IDLE);
  assign out_wr_en      = wr_en_q;
  assign out_wr_address = wr_addr_q;
  assign out_wr_data    = wr_data_q;
  assign out_cursor_x   = cur_x_q;
  assign out_cursor_y   = cur_y_q;

endmodule
`default_nettype wire
